// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status pulses out.
// master = receiver side, slave = line driver / byte consumer.
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    modport master (
        input  rx_in,
        output p_data, data_valid, parity_error, stop_error, busy
    );

    modport slave (
        output rx_in,
        input  p_data, data_valid, parity_error, stop_error, busy
    );
endinterface

// File: rtl/uart_rx.sv
// Purpose: 8-bit LSB-first UART receiver, mid-bit sampling, optional parity, framing/parity flags.
// Latency: busy 3 clks after start edge; data_valid/error pulse 1 clk after the stop-bit sample.
// Backpressure: none; data_valid is a one-cycle strobe and the consumer must take it.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PAR_EN       = 0,
    parameter int PAR_TYP      = 0
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master rx
);
    localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] MID     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic          PAR_ODD = (PAR_TYP != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic          sync1, sync2, prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bad;
    logic [7:0]    p_data_q;
    logic          dv_q, pe_q, se_q;
    logic          samp;

    // Line idles high, so every stage resets to 1 to avoid a phantom start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx.rx_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        samp      = 1'b0;
        case (state)
            IDLE: begin
                if (prev && !sync2) state_nxt = START;
            end
            START: begin
                if (cnt == MID) begin
                    samp      = 1'b1;
                    state_nxt = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    samp = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = (PAR_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (cnt == LAST) begin
                    samp      = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    samp      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            p_data_q <= '0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;

            if (state == IDLE || samp) cnt <= '0;
            else                       cnt <= cnt + CW'(1);

            if (samp) begin
                case (state)
                    START: begin
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                    end
                    DATA: begin
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    PARITY: begin
                        par_bad <= (sync2 != (^shreg ^ PAR_ODD));
                    end
                    STOP: begin
                        // A byte is only delivered when both stop and parity are good.
                        if (sync2 && !par_bad) begin
                            p_data_q <= shreg;
                            dv_q     <= 1'b1;
                        end else if (!sync2) begin
                            se_q <= 1'b1;
                            pe_q <= par_bad;
                        end else begin
                            pe_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx.p_data       = p_data_q;
    assign rx.data_valid   = dv_q;
    assign rx.parity_error = pe_q;
    assign rx.stop_error   = se_q;
    assign rx.busy         = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one 8N1 and one 8E1 receiver, frame-level scoreboard plus directed literals.
module tb_uart_rx;
    localparam int C         = 16;
    localparam int PAR_TYP_P = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if bus_n ();
    uart_rx_if bus_p ();
    logic line_n = 1'b1;
    logic line_p = 1'b1;
    assign bus_n.rx_in = line_n;
    assign bus_p.rx_in = line_p;

    uart_rx #(.CLKS_PER_BIT(C), .PAR_EN(0), .PAR_TYP(0)) dut_n (
        .clk(clk), .rst(rst), .rx(bus_n.master)
    );
    uart_rx #(.CLKS_PER_BIT(C), .PAR_EN(1), .PAR_TYP(PAR_TYP_P)) dut_p (
        .clk(clk), .rst(rst), .rx(bus_p.master)
    );

    // kind: 0 good byte, 1 parity error, 2 stop error, 3 stop + parity error
    typedef struct {
        int         kind;
        logic [7:0] dat;
        longint     due;
    } ev_t;

    ev_t        q_n[$];
    ev_t        q_p[$];
    longint     cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] mpd [2] = '{8'h00, 8'h00};
    longint     dv_last [2] = '{0, 0};
    longint     dv_prev [2] = '{0, 0};
    longint     busy_rise [2] = '{0, 0};
    longint     busy_fall [2] = '{0, 0};
    longint     start_cyc [2] = '{0, 0};
    logic       busy_prev [2] = '{1'b0, 1'b0};
    int         n_dv [2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic cmp_dut(input int d, input logic dv, input logic pe, input logic se,
                           input logic busy, input logic [7:0] pd);
        ev_t  ev;
        logic has;
        if (busy && !busy_prev[d]) busy_rise[d] = cyc;
        if (!busy && busy_prev[d]) busy_fall[d] = cyc;
        busy_prev[d] = busy;
        has = (d == 0) ? (q_n.size() > 0) : (q_p.size() > 0);
        if (dv || pe || se) begin
            if (!has) begin
                total++;
                bad++;
                $display("FAIL dut%0d_unexpected_pulse: got dv=%b pe=%b se=%b expected none (cycle %0d)",
                         d, dv, pe, se, cyc);
            end else begin
                if (d == 0) ev = q_n.pop_front();
                else        ev = q_p.pop_front();
                chk($sformatf("dut%0d_data_valid", d), 64'(dv), 64'(ev.kind == 0));
                chk($sformatf("dut%0d_parity_error", d), 64'(pe), 64'(ev.kind == 1 || ev.kind == 3));
                chk($sformatf("dut%0d_stop_error", d), 64'(se), 64'(ev.kind >= 2));
                chk($sformatf("dut%0d_busy_at_pulse", d), 64'(busy), 64'd0);
                chk_rng($sformatf("dut%0d_pulse_time", d), cyc, ev.due - 1, ev.due + 1);
                if (dv) begin
                    mpd[d]     = ev.dat;
                    n_dv[d]    = n_dv[d] + 1;
                    dv_prev[d] = dv_last[d];
                    dv_last[d] = cyc;
                end
            end
        end else if (has) begin
            ev = (d == 0) ? q_n[0] : q_p[0];
            if (cyc > ev.due + 1) begin
                total++;
                bad++;
                $display("FAIL dut%0d_missing_pulse: got none by cycle %0d expected kind %0d by %0d",
                         d, cyc, ev.kind, ev.due);
                if (d == 0) void'(q_n.pop_front());
                else        void'(q_p.pop_front());
            end
        end
        chk($sformatf("dut%0d_p_data", d), 64'(pd), 64'(mpd[d]));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, bus_n.data_valid, bus_n.parity_error, bus_n.stop_error, bus_n.busy, bus_n.p_data);
        cmp_dut(1, bus_p.data_valid, bus_p.parity_error, bus_p.stop_error, bus_p.busy, bus_p.p_data);
    end

    task automatic drive_bit(input int d, input logic v);
        if (d == 0) line_n = v;
        else        line_p = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    // Transmitter model: start, 8 data LSB first, parity (dut_p only), stop, idle bits.
    task automatic send_frame(input int d, input logic [7:0] b, input logic par_flip,
                              input logic stop_bit, input int idle_bits);
        ev_t  ev;
        int   stop_idx;
        logic pe;
        stop_idx = (d == 1) ? 10 : 9;
        pe       = (d == 1) && par_flip;
        ev.dat   = b;
        ev.due   = cyc + longint'(stop_idx * C + C / 2 + 3);
        ev.kind  = !stop_bit ? (pe ? 3 : 2) : (pe ? 1 : 0);
        start_cyc[d] = cyc;
        if (d == 0) q_n.push_back(ev);
        else        q_p.push_back(ev);
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, b[i]);
        if (d == 1) drive_bit(d, (^b) ^ (PAR_TYP_P != 0) ^ par_flip);
        drive_bit(d, stop_bit);
        repeat (idle_bits) drive_bit(d, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        longint     s;
        longint     r;
        int         n0;
        logic [7:0] rom [3];
        rom[0] = 8'h55;
        rom[1] = 8'hC3;
        rom[2] = 8'h0F;

        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_p_data_n", 64'(bus_n.p_data), 64'h00);
        chk("rst_valid_n", 64'(bus_n.data_valid), 64'd0);
        chk("rst_perr_n", 64'(bus_n.parity_error), 64'd0);
        chk("rst_serr_n", 64'(bus_n.stop_error), 64'd0);
        chk("rst_busy_n", 64'(bus_n.busy), 64'd0);
        chk("rst_busy_p", 64'(bus_p.busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // single 8N1 frame
        send_frame(0, 8'hA5, 1'b0, 1'b1, 2);
        chk("a5_latency", 64'(dv_last[0] - start_cyc[0]), 64'd155);
        chk("a5_busy_rise", 64'(busy_rise[0] - start_cyc[0]), 64'd3);
        chk("a5_busy_fall", 64'(busy_fall[0] - start_cyc[0]), 64'd155);
        chk("a5_p_data", 64'(bus_n.p_data), 64'hA5);

        // false start: 3 clocks low
        n0 = n_dv[0];
        s  = cyc;
        line_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 line_n = 1'b1;
        repeat (2 * C) @(posedge clk);
        #1;
        chk("fs_busy_rise", 64'(busy_rise[0] - s), 64'd3);
        chk_rng("fs_busy_fall", busy_fall[0] - s, 4, C);
        chk("fs_no_valid", 64'(n_dv[0]), 64'(n0));

        // framing error, then a held break
        send_frame(0, 8'h3C, 1'b0, 1'b0, 0);
        r = busy_rise[0];
        repeat (3 * C) @(posedge clk);
        #1;
        chk("break_no_start", 64'(busy_rise[0]), 64'(r));
        chk("break_busy", 64'(bus_n.busy), 64'd0);
        chk("fe_p_data", 64'(bus_n.p_data), 64'hA5);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);

        // parity receiver
        send_frame(1, 8'h07, 1'b0, 1'b1, 1);
        chk("par_good_p_data", 64'(bus_p.p_data), 64'h07);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1);
        chk("par_bad_p_data", 64'(bus_p.p_data), 64'h07);
        send_frame(1, 8'h5A, 1'b1, 1'b0, 2);
        chk("par_stop_p_data", 64'(bus_p.p_data), 64'h07);

        // back-to-back, no idle between frames
        send_frame(0, 8'h00, 1'b0, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 2);
        chk("b2b_gap", 64'(dv_last[0] - dv_prev[0]), 64'(10 * C));
        chk("b2b_p_data", 64'(bus_n.p_data), 64'hFF);

        // reset during data bit 4
        fork
            send_frame(0, 8'h96, 1'b0, 1'b1, 2);
            begin
                repeat (5 * C + 8) @(posedge clk);
                #1 rst = 1'b0;
                q_n.delete();
                q_p.delete();
                mpd[0] = 8'h00;
                mpd[1] = 8'h00;
                @(negedge clk);
                chk("mid_rst_p_data", 64'(bus_n.p_data), 64'h00);
                chk("mid_rst_busy", 64'(bus_n.busy), 64'd0);
                chk("mid_rst_valid", 64'(bus_n.data_valid), 64'd0);
                chk("mid_rst_p_data_p", 64'(bus_p.p_data), 64'h00);
            end
        join
        rst = 1'b1;
        drive_bit(0, 1'b1);

        // loopback of transmitter ROM words
        for (int i = 0; i < 3; i++) begin
            send_frame(0, rom[i], 1'b0, 1'b1, 1);
            chk($sformatf("loop_%0d", i), 64'(bus_n.p_data), 64'(rom[i]));
        end

        // randomized streams on both receivers
        fork
            begin : rnd_n
                logic [7:0] bn;
                logic       sn;
                int         in_;
                for (int i = 0; i < 30; i++) begin
                    bn  = 8'($urandom_range(0, 255));
                    sn  = ($urandom_range(0, 7) != 0);
                    in_ = sn ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
                    send_frame(0, bn, 1'b0, sn, in_);
                end
            end
            begin : rnd_p
                logic [7:0] bp;
                logic       sp;
                logic       fp;
                int         ip;
                for (int i = 0; i < 30; i++) begin
                    bp = 8'($urandom_range(0, 255));
                    sp = ($urandom_range(0, 7) != 0);
                    fp = ($urandom_range(0, 3) == 0);
                    ip = sp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
                    send_frame(1, bp, fp, sp, ip);
                end
            end
        join

        repeat (4 * C) @(posedge clk);
        #1;
        chk("drain_n", 64'(q_n.size()), 64'd0);
        chk("drain_p", 64'(q_p.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
